// File: rtl/flit_serializer_param.sv
// flit_serializer_param: breaks whole flits into LANE_W-bit beats for a narrow
// link. An active flit (cur) drains beat by beat while a one-flit holding
// register (nxt) absorbs the next flit, so back-to-back flits leave no bubbles.
module flit_serializer_param #(
  parameter int FLIT_W    = 64,
  parameter int LANE_W    = 4,
  parameter int VC_W      = 2,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] in_data,
  input  logic [VC_W-1:0]   in_vc,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [LANE_W-1:0] out_data,
  output logic [VC_W-1:0]   out_vc,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy
);

  localparam int BEATS = FLIT_W / LANE_W;
  localparam int CNT_W = $clog2(BEATS);

  logic [FLIT_W-1:0] cur, nxt;
  logic [VC_W-1:0]   cur_vc, nxt_vc;
  logic [CNT_W-1:0]  cnt;
  logic              act, nxt_full;

  logic [BEATS-1:0][LANE_W-1:0] cur_beats;
  logic [CNT_W-1:0]             sel;
  logic                         xfer, last, cur_free, accept;

  // Beat view of the active flit; beat index follows the configured order.
  assign cur_beats = cur;
  assign sel       = (MSB_FIRST != 0) ? (CNT_W'(BEATS - 1) - cnt) : cnt;

  // in_ready depends on state only, so no combinational path from in_valid
  // or out_ready reaches it.
  assign in_ready  = !nxt_full;
  assign accept    = in_valid && in_ready;
  assign last      = act && (cnt == CNT_W'(BEATS - 1));
  assign xfer      = act && out_ready;
  assign cur_free  = !act || (xfer && last);

  assign out_valid = act;
  assign out_last  = last;
  assign out_vc    = cur_vc;
  assign out_data  = act ? cur_beats[sel] : '0;
  assign busy      = act || nxt_full;

  // Beat counter plus active/holding register hand-off; a pending flit in nxt
  // always beats a fresh one so flit order is preserved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= '0;
      cur_vc   <= '0;
      nxt      <= '0;
      nxt_vc   <= '0;
      cnt      <= '0;
      act      <= 1'b0;
      nxt_full <= 1'b0;
    end else begin
      if (xfer) cnt <= last ? '0 : cnt + 1'b1;
      if (cur_free) begin
        if (nxt_full) begin
          cur      <= nxt;
          cur_vc   <= nxt_vc;
          act      <= 1'b1;
          nxt_full <= 1'b0;
        end else if (accept) begin
          cur    <= in_data;
          cur_vc <= in_vc;
          act    <= 1'b1;
        end else begin
          act <= 1'b0;
        end
      end else if (accept) begin
        nxt      <= in_data;
        nxt_vc   <= in_vc;
        nxt_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flit_serializer_param.sv
// Directed bench for flit_serializer_param: default LSB-first instance, an
// MSB-first instance and a 32/8/1 instance share clock, reset and out_ready.
module tb_flit_serializer_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic out_ready;

  logic [63:0] in_data;
  logic [1:0]  in_vc;
  logic        in_valid0, in_valid1;
  logic        in_ready0, in_ready1;
  logic [3:0]  od0, od1;
  logic [1:0]  ovc0, ovc1;
  logic        ov0, ov1, ol0, ol1, busy0, busy1;

  logic [31:0] in_data2;
  logic        in_vc2, in_valid2, in_ready2;
  logic [7:0]  od2;
  logic        ovc2, ov2, ol2, busy2;

  int n_cmp = 0;
  int n_err = 0;

  flit_serializer_param u0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_vc(in_vc),
    .in_valid(in_valid0), .in_ready(in_ready0), .out_data(od0), .out_vc(ovc0),
    .out_valid(ov0), .out_last(ol0), .out_ready(out_ready), .busy(busy0)
  );

  flit_serializer_param #(.MSB_FIRST(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_vc(in_vc),
    .in_valid(in_valid1), .in_ready(in_ready1), .out_data(od1), .out_vc(ovc1),
    .out_valid(ov1), .out_last(ol1), .out_ready(out_ready), .busy(busy1)
  );

  flit_serializer_param #(.FLIT_W(32), .LANE_W(8), .VC_W(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_vc(in_vc2),
    .in_valid(in_valid2), .in_ready(in_ready2), .out_data(od2), .out_vc(ovc2),
    .out_valid(ov2), .out_last(ol2), .out_ready(out_ready), .busy(busy2)
  );

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({ov0, ol0, od0, ovc0, busy0, in_ready0} !== {1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_u0: got v=%b l=%b d=%h vc=%0d busy=%b rdy=%b want 0 0 0 0 0 1",
               ov0, ol0, od0, ovc0, busy0, in_ready0);
    end
    n_cmp++;
    if ({ov2, ol2, od2, ovc2, busy2, in_ready2} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_u2: got v=%b l=%b d=%h vc=%0d busy=%b rdy=%b want 0 0 0 0 0 1",
               ov2, ol2, od2, ovc2, busy2, in_ready2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One flit, unstalled link: beat 0 must appear in the cycle after accept.
  task automatic test_single(input bit msb);
    logic [3:0] d, exp_d;
    logic [1:0] vc;
    logic v, l, b;
    @(negedge clk);
    out_ready = 1'b1;
    in_data   = 64'hFEDC_BA98_7654_3210;
    in_vc     = 2'd2;
    if (msb) in_valid1 = 1'b1; else in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      d = msb ? od1 : od0;  vc = msb ? ovc1 : ovc0;
      v = msb ? ov1 : ov0;  l  = msb ? ol1 : ol0;
      exp_d = msb ? 4'(15 - i) : 4'(i);
      n_cmp++;
      if ({v, l, vc, d} !== {1'b1, (i == 15), 2'd2, exp_d}) begin
        n_err++;
        $display("FAIL single_msb%0d beat %0d: got v=%b l=%b vc=%0d d=%h want 1 %b 2 %h",
                 msb, i, v, l, vc, d, (i == 15), exp_d);
      end
      @(negedge clk);
    end
    v = msb ? ov1 : ov0;  b = msb ? busy1 : busy0;  d = msb ? od1 : od0;
    n_cmp++;
    if ({v, b, d} !== {1'b0, 1'b0, 4'h0}) begin
      n_err++;
      $display("FAIL single_msb%0d drain: got v=%b busy=%b d=%h want 0 0 0", msb, v, b, d);
    end
  endtask

  // Three flits offered as fast as accepted; 48 contiguous beats expected.
  task automatic test_back_to_back();
    logic [63:0] fl [3];
    logic [1:0]  vcs [3];
    logic [63:0] f;
    logic [3:0]  exp_d;
    logic        exp_rdy;
    int idx, k, gaps;
    bit rdy_q;
    fl[0] = 64'h0123_4567_89AB_CDEF;  vcs[0] = 2'd1;
    fl[1] = 64'hFEDC_BA98_7654_3210;  vcs[1] = 2'd2;
    fl[2] = 64'h1111_2222_3333_4444;  vcs[2] = 2'd3;
    idx = 0; k = 0; gaps = 0; rdy_q = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && k < 48; cyc++) begin
      if (in_valid0 && rdy_q) idx++;
      if (ov0) begin
        f = fl[k / 16];
        exp_d = f[4 * (k % 16) +: 4];
        exp_rdy = ((k % 16) == 0) || (k >= 32);
        n_cmp++;
        if ({od0, ovc0, ol0, in_ready0} !== {exp_d, vcs[k / 16], ((k % 16) == 15), exp_rdy}) begin
          n_err++;
          $display("FAIL b2b beat %0d: got d=%h vc=%0d l=%b rdy=%b want %h %0d %b %b",
                   k, od0, ovc0, ol0, in_ready0, exp_d, vcs[k / 16], ((k % 16) == 15), exp_rdy);
        end
        k++;
      end else if (k > 0) begin
        gaps++;
      end
      in_valid0 = (idx < 3);
      if (idx < 3) begin
        in_data = fl[idx];
        in_vc   = vcs[idx];
      end
      rdy_q = in_ready0;
      @(negedge clk);
    end
    in_valid0 = 1'b0;
    n_cmp++;
    if (k !== 48 || gaps !== 0) begin
      n_err++;
      $display("FAIL b2b count: got beats=%0d gaps=%0d want 48 0", k, gaps);
    end
    n_cmp++;
    if ({ov0, busy0} !== 2'b00) begin
      n_err++;
      $display("FAIL b2b drain: got v=%b busy=%b want 0 0", ov0, busy0);
    end
  endtask

  // Random link backpressure: the offered beat always equals the next expected
  // beat, so a stalled beat must hold and none may be lost or repeated.
  task automatic test_stall();
    logic [63:0] fl [2];
    logic [1:0]  vcs [2];
    logic [63:0] f;
    logic [3:0]  exp_d;
    logic        r;
    int idx, k;
    bit rdy_q;
    fl[0] = 64'hFEDC_BA98_7654_3210;  vcs[0] = 2'd1;
    fl[1] = 64'h0123_4567_89AB_CDEF;  vcs[1] = 2'd3;
    idx = 0; k = 0; rdy_q = 1'b0;
    @(negedge clk);
    for (int cyc = 0; cyc < 400 && k < 32; cyc++) begin
      if (in_valid0 && rdy_q) idx++;
      r = 1'($urandom_range(0, 1));
      out_ready = r;
      if (ov0) begin
        f = fl[k / 16];
        exp_d = f[4 * (k % 16) +: 4];
        n_cmp++;
        if ({od0, ovc0, ol0, busy0} !== {exp_d, vcs[k / 16], ((k % 16) == 15), 1'b1}) begin
          n_err++;
          $display("FAIL stall beat %0d rdy=%b: got d=%h vc=%0d l=%b busy=%b want %h %0d %b 1",
                   k, r, od0, ovc0, ol0, busy0, exp_d, vcs[k / 16], ((k % 16) == 15));
        end
        if (r) k++;
      end
      in_valid0 = (idx < 2);
      if (idx < 2) begin
        in_data = fl[idx];
        in_vc   = vcs[idx];
      end
      rdy_q = in_ready0;
      @(negedge clk);
    end
    in_valid0 = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (k !== 32 || ov0 !== 1'b0) begin
      n_err++;
      $display("FAIL stall count: got beats=%0d v=%b want 32 0", k, ov0);
    end
  endtask

  // Two 32-bit flits back-to-back: 4 byte beats each, last on beats 4 and 8.
  task automatic test_flit32();
    logic [7:0] exp_d [8];
    logic       exp_vc [8];
    exp_d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
    exp_vc = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    @(negedge clk);
    out_ready = 1'b1;
    in_data2  = 32'hDDCC_BBAA;
    in_vc2    = 1'b1;
    in_valid2 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({ov2, od2, ovc2, ol2} !== {1'b1, exp_d[i], exp_vc[i], (i == 3 || i == 7)}) begin
        n_err++;
        $display("FAIL flit32 beat %0d: got v=%b d=%h vc=%0d l=%b want 1 %h %0d %b",
                 i, ov2, od2, ovc2, ol2, exp_d[i], exp_vc[i], (i == 3 || i == 7));
      end
      if (i == 0) begin
        n_cmp++;
        if (in_ready2 !== 1'b1) begin
          n_err++;
          $display("FAIL flit32 in_ready: got %b want 1", in_ready2);
        end
        in_data2 = 32'h4433_2211;
        in_vc2   = 1'b0;
      end
      if (i == 1) in_valid2 = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if ({ov2, busy2} !== 2'b00) begin
      n_err++;
      $display("FAIL flit32 drain: got v=%b busy=%b want 0 0", ov2, busy2);
    end
  endtask

  // Reset during beat 7 with a flit pending in nxt: everything is dropped.
  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b1;
    in_data   = 64'hFEDC_BA98_7654_3210;
    in_vc     = 2'd2;
    in_valid0 = 1'b1;
    @(negedge clk);
    in_data = 64'h0123_4567_89AB_CDEF;
    in_vc   = 2'd1;
    @(negedge clk);
    in_valid0 = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({ov0, od0, busy0, in_ready0} !== {1'b1, 4'h7, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL rstmid pre: got v=%b d=%h busy=%b rdy=%b want 1 7 1 0", ov0, od0, busy0, in_ready0);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ov0, ol0, od0, ovc0, busy0, in_ready0} !== {1'b0, 1'b0, 4'h0, 2'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL rstmid async: got v=%b l=%b d=%h vc=%0d busy=%b rdy=%b want 0 0 0 0 0 1",
               ov0, ol0, od0, ovc0, busy0, in_ready0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({ov0, busy0} !== 2'b00) begin
        n_err++;
        $display("FAIL rstmid idle %0d: got v=%b busy=%b want 0 0", i, ov0, busy0);
      end
    end
    in_data   = 64'h1111_2222_3333_4444;
    in_vc     = 2'd3;
    in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    n_cmp++;
    if ({ov0, od0, ovc0} !== {1'b1, 4'h4, 2'd3}) begin
      n_err++;
      $display("FAIL rstmid restart: got v=%b d=%h vc=%0d want 1 4 3", ov0, od0, ovc0);
    end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    out_ready = 1'b1;
    in_data = '0;  in_vc = '0;  in_valid0 = 1'b0;  in_valid1 = 1'b0;
    in_data2 = '0; in_vc2 = 1'b0; in_valid2 = 1'b0;
    test_reset();
    test_single(1'b0);
    test_single(1'b1);
    test_back_to_back();
    test_stall();
    test_flit32();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
